// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
// Owns the program counter. Requests instructions from a variable-latency
// instruction memory over a valid/ready request and valid-qualified response
// interface. Registers the returned word, exposes its decoded fields, and
// computes the next PC from the execute-stage decision when the core retires
// the instruction. Bus errors, response timeouts and misaligned next-PC
// targets all trap into a sticky fault state that only reset leaves.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   imem_req_valid/ready, imem_addr              fetch request channel
//   imem_rsp_valid, imem_rsp_data, imem_rsp_err  fetch response channel
//   instr, instr_valid, op_code, funct3, funct7  held instruction and fields
//   instr_ack, pc_src, imm_ext                   retire and next-PC decision
//   pc_current, pc_plus4                         current PC and PC+4
//   fetch_fault                                  sticky fault flag
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_1000,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [6:0]  op_code,
  output logic [2:0]  funct3,
  output logic        funct7,
  input  logic        instr_ack,
  input  logic        pc_src,
  input  logic [31:0] imm_ext,
  output logic [31:0] pc_current,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic [31:0] pc_target;
  logic        target_misaligned;
  logic        rsp_ok;
  logic        rsp_bad;

  // Candidate next PC; only acted upon when an ack arrives in VALID.
  assign pc_target         = pc_current + (pc_src ? imm_ext : 32'd4);
  assign target_misaligned = (pc_target[1:0] != 2'b00);

  assign rsp_ok  = imem_rsp_valid && !imem_rsp_err;
  assign rsp_bad = imem_rsp_valid &&  imem_rsp_err;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = REQ;
      REQ:   if (imem_req_ready) state_next = WAIT;
      WAIT: begin
        // A response on the same edge as the timeout takes priority.
        if (rsp_ok)                     state_next = VALID;
        else if (rsp_bad)               state_next = FAULT;
        else if (wait_cnt == CNT_LAST)  state_next = FAULT;
      end
      VALID: begin
        if (instr_ack) state_next = target_misaligned ? FAULT : REQ;
      end
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pc_current <= RESET_VECTOR;
      instr      <= NOP;
      wait_cnt   <= 8'd0;
    end else begin
      state <= state_next;
      if (state == REQ && imem_req_ready) wait_cnt <= 8'd0;
      else if (state == WAIT)             wait_cnt <= wait_cnt + 8'd1;
      if (state == WAIT && rsp_ok) instr <= imem_rsp_data;
      // A misaligned target leaves the PC pointing at the faulting instruction.
      if (state == VALID && instr_ack && !target_misaligned) pc_current <= pc_target;
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc_current;
  assign instr_valid    = (state == VALID);
  assign fetch_fault    = (state == FAULT);
  assign pc_plus4       = pc_current + 32'd4;
  assign op_code        = instr[6:0];
  assign funct3         = instr[14:12];
  assign funct7         = instr[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed stimulus, a transaction-level
// reference model checked every cycle, plus literal expectations.
module tb_instr_fetch_unit;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] RV      = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic [31:0] instr;
  logic        instr_valid;
  logic [6:0]  op_code;
  logic [2:0]  funct3;
  logic        funct7;
  logic        instr_ack;
  logic        pc_src;
  logic [31:0] imm_ext;
  logic [31:0] pc_current;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit #(.RESET_VECTOR(RV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .instr(instr), .instr_valid(instr_valid),
    .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .instr_ack(instr_ack), .pc_src(pc_src), .imm_ext(imm_ext),
    .pc_current(pc_current), .pc_plus4(pc_plus4), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks what the fetch unit has to do in terms of
  // transactions (a request pending, a request outstanding for some number
  // of cycles, an instruction held for the core, a trap) rather than states.
  logic        m_on = 1'b0;
  logic [31:0] m_pc, m_instr, m_tgt;
  logic        m_fault, m_bubble, m_req, m_outst, m_have;
  int          m_wcyc;

  always @(posedge clk) begin
    if (!rst) begin
      m_on = 1'b1; m_pc = RV; m_instr = 32'h0000_0013;
      m_fault = 1'b0; m_bubble = 1'b1; m_req = 1'b0;
      m_outst = 1'b0; m_have = 1'b0; m_wcyc = 0;
    end else if (m_on && !m_fault) begin
      if (m_bubble) begin
        m_bubble = 1'b0; m_req = 1'b1;
      end else if (m_req) begin
        if (imem_req_ready) begin m_req = 1'b0; m_outst = 1'b1; m_wcyc = 0; end
      end else if (m_outst) begin
        m_wcyc++;
        if (imem_rsp_valid) begin
          m_outst = 1'b0;
          if (imem_rsp_err) m_fault = 1'b1;
          else begin m_instr = imem_rsp_data; m_have = 1'b1; end
        end else if (m_wcyc == TIMEOUT) begin
          m_outst = 1'b0; m_fault = 1'b1;
        end
      end else if (m_have && instr_ack) begin
        m_tgt  = m_pc + (pc_src ? imm_ext : 32'd4);
        m_have = 1'b0;
        if (m_tgt % 4 != 0) m_fault = 1'b1;
        else begin m_pc = m_tgt; m_req = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      cmp("m_req_valid", 32'(imem_req_valid), 32'(m_req));
      cmp("m_addr", imem_addr, m_pc);
      cmp("m_pc_current", pc_current, m_pc);
      cmp("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      cmp("m_instr", instr, m_instr);
      cmp("m_instr_valid", 32'(instr_valid), 32'(m_have));
      cmp("m_fault", 32'(fetch_fault), 32'(m_fault));
      cmp("m_op_code", 32'(op_code), 32'(m_instr[6:0]));
      cmp("m_funct3", 32'(funct3), 32'(m_instr[14:12]));
      cmp("m_funct7", 32'(funct7), 32'(m_instr[30]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, accept it, respond after k cycles.
  task automatic fetch(input logic [31:0] data, input int k);
    int n = 0;
    while (!imem_req_valid && n < 20) begin tick(); n++; end
    if (!imem_req_valid) begin
      checks++; failures++;
      $display("FAIL fetch_req_timeout: no request within %0d cycles", n);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    repeat (k - 1) tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = data;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic ack(input logic src, input logic [31:0] imm);
    instr_ack = 1'b1; pc_src = src; imm_ext = imm;
    tick();
    instr_ack = 1'b0; pc_src = 1'b0; imm_ext = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'd0; imem_rsp_err = 1'b0;
    instr_ack = 1'b0; pc_src = 1'b0; imm_ext = 32'd0;
    tick(); tick();
    cmp("rst_addr", imem_addr, 32'h0000_1000);
    cmp("rst_instr", instr, 32'h0000_0013);
    cmp("rst_req_valid", 32'(imem_req_valid), 32'd0);
    cmp("rst_fault", 32'(fetch_fault), 32'd0);
    rst = 1'b1;
    tick();
    cmp("bubble_then_req", 32'(imem_req_valid), 32'd1);

    // Sequential fetch.
    fetch(32'h0050_0093, 1);
    cmp("first_valid", 32'(instr_valid), 32'd1);
    cmp("first_opcode", 32'(op_code), 32'h13);
    cmp("first_funct3", 32'(funct3), 32'd0);
    ack(1'b0, 32'd0);
    cmp("seq_addr", imem_addr, 32'h0000_1004);
    fetch(32'h4000_5033, 2);
    cmp("funct7_bit", 32'(funct7), 32'd1);
    cmp("funct3_5", 32'(funct3), 32'd5);
    ack(1'b0, 32'd0);
    cmp("seq_addr2", imem_addr, 32'h0000_1008);

    // Branches backward and forward.
    fetch(32'hFE00_0CE3, 1);
    ack(1'b1, 32'hFFFF_FFF8);
    cmp("branch_back", imem_addr, 32'h0000_1000);
    fetch(32'h0000_006F, 3);
    ack(1'b1, 32'd16);
    cmp("branch_fwd", imem_addr, 32'h0000_1010);

    // Backpressure: request held with a stable address.
    imem_req_ready = 1'b0;
    repeat (5) tick();
    cmp("bp_req_held", 32'(imem_req_valid), 32'd1);
    cmp("bp_addr_held", imem_addr, 32'h0000_1010);
    fetch(32'h0010_0113, 1);
    cmp("bp_valid", 32'(instr_valid), 32'd1);
    cmp("bp_no_dup_req", 32'(imem_req_valid), 32'd0);

    // Spurious response while holding an instruction.
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    cmp("spurious_ignored", instr, 32'h0010_0113);

    // Misaligned target.
    ack(1'b1, 32'd2);
    cmp("misalign_fault", 32'(fetch_fault), 32'd1);
    cmp("misalign_pc", pc_current, 32'h0000_1010);
    repeat (3) tick();
    cmp("misalign_no_req", 32'(imem_req_valid), 32'd0);
    do_reset();
    cmp("fault_reset_addr", imem_addr, 32'h0000_1000);
    cmp("fault_reset_clear", 32'(fetch_fault), 32'd0);

    // Timeout: fault exactly TIMEOUT cycles after entering WAIT.
    tick();
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    repeat (TIMEOUT - 1) tick();
    cmp("timeout_not_yet", 32'(fetch_fault), 32'd0);
    tick();
    cmp("timeout_fault", 32'(fetch_fault), 32'd1);
    do_reset();
    cmp("timeout_reset_addr", imem_addr, 32'h0000_1000);

    // Bus error.
    tick();
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    cmp("err_fault", 32'(fetch_fault), 32'd1);
    do_reset();

    // Response on the timeout edge is accepted.
    tick();
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    repeat (TIMEOUT - 1) tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0193; tick();
    imem_rsp_valid = 1'b0;
    cmp("late_rsp_valid", 32'(instr_valid), 32'd1);
    cmp("late_rsp_nofault", 32'(fetch_fault), 32'd0);

    // PC wrap from 0xFFFF_FFFC to 0.
    ack(1'b1, 32'hFFFF_EFFC);
    cmp("jump_top", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0013, 1);
    cmp("top_plus4", pc_plus4, 32'h0000_0000);
    ack(1'b0, 32'd0);
    cmp("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset in the middle of WAIT.
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    tick();
    do_reset();
    cmp("midwait_addr", imem_addr, 32'h0000_1000);
    cmp("midwait_req", 32'(imem_req_valid), 32'd0);
    tick();
    cmp("midwait_req_again", 32'(imem_req_valid), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the main/ALU decoder.
- Owns the program counter and runs a valid/ready request/response handshake with a variable-latency instruction memory.
- Registers the returned instruction and presents it, with its decoded fields, to the control unit and datapath.
- Computes the next PC from the PC_Src/immediate decision fed back from execute. Traps bus errors, timeouts and misaligned targets into a sticky fault state.

Parameters:
- RESET_VECTOR, 32'h0000_1000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles in WAIT before a fetch fault (range 2..255).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  fetch address, always equal to pc_current.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  returned instruction word.
- imem_rsp_err  in  1  bus error, qualified by imem_rsp_valid.
- instr  out  32  registered instruction.
- instr_valid  out  1  instr holds a fresh instruction for execution.
- op_code  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  1  instr[30].
- instr_ack  in  1  core retires the current instruction this cycle.
- pc_src  in  1  0: next = pc+4; 1: next = pc+imm_ext. Sampled only with instr_ack.
- imm_ext  in  32  sign-extended branch/jump offset.
- pc_current  out  32  PC of the instruction being fetched or held.
- pc_plus4  out  32  pc_current+4, combinational, used for jal writeback.
- fetch_fault  out  1  sticky fault flag.

Behaviour:
- Reset (rst=0 at an edge):
  - pc_current=RESET_VECTOR, state=IDLE.
  - instr=32'h0000_0013 (nop), instr_valid=0, imem_req_valid=0, fetch_fault=0, timeout counter=0.
  - Reset mid-operation (any state) aborts the fetch immediately.
  - The memory must be reset by the same rst; a pre-reset response is not filtered.
- FSM states: IDLE, REQ, WAIT, VALID, FAULT.
  - IDLE: outputs quiet; unconditionally goes to REQ on the next edge, so one bubble after reset release.
  - REQ: imem_req_valid=1, imem_addr=pc_current. When imem_req_ready=1, go to WAIT and clear the counter. Otherwise stay, holding addr stable and keeping valid high (no retraction).
  - WAIT: imem_req_valid=0; counter increments each cycle.
    - rsp_valid & !rsp_err: instr<=rsp_data, go to VALID.
    - rsp_valid & rsp_err: go to FAULT.
    - counter reaches TIMEOUT-1 with no response: go to FAULT.
    - A response in the same edge as the timeout wins (is accepted).
  - VALID: instr_valid=1, instr held stable. On instr_ack=1:
    - pc_next = pc_src ? pc_current+imm_ext : pc_current+4, modulo 2^32 (wrap from 0xFFFF_FFFC to 0 is legal).
    - If pc_next[1:0]!=0, go to FAULT and leave pc_current unchanged.
    - Otherwise pc_current<=pc_next, instr_valid drops, go to REQ.
    - Without ack, stay indefinitely.
  - FAULT: fetch_fault=1, instr_valid=0, imem_req_valid=0. Exit only by reset. pc_current holds the faulting instruction's PC.
- Responses arriving in IDLE, REQ, VALID or FAULT are ignored.
- instr_ack while instr_valid=0 is ignored; pc_src and imm_ext are don't-care then.
- Latency: REQ handshake at edge N, response during cycle N+k (k≥1), instr_valid high from edge N+k onward.
  - Steady state with k=1 and immediate ack gives one instruction per 3 cycles.
- op_code, funct3 and funct7 are pure slices of the instr register; they track instr in every state.

Test Plan:
- Reset release, ready=1, rsp one cycle after accept with data 32'h0050_0093 → addr=0x1000, instr_valid rises, op_code=7'h13, funct3=0; ack with pc_src=0 → next addr=0x1004.
- Branch: in VALID at pc=0x1008, ack with pc_src=1, imm_ext=32'hFFFF_FFF8 → next addr=0x1000; then imm_ext=+16 → 0x1010.
- Backpressure: hold imem_req_ready=0 for 5 cycles → req_valid and addr stay stable; accept on cycle 6; no duplicate request.
- Timeout: TIMEOUT=16, no response after accept → fetch_fault=1 exactly 16 cycles after entering WAIT. Separately, rsp_err=1 → immediate FAULT. In both cases rst=0 clears to addr 0x1000.
- Misaligned target: ack with pc_src=1, imm_ext=2 → FAULT, pc_current unchanged, no new request.
- Reset mid-WAIT and spurious rsp_valid in VALID → state returns to IDLE/REQ at 0x1000; instr unchanged by the spurious response.
